// File: rtl/onchip_ram_dp_pipe.sv
// Dual-slave Avalon-MM on-chip RAM with byte enables, a 1- or 2-stage
// readdatavalid pipeline, a shared stall (waitrequest) and defined collision
// behaviour. s1 and s2 see the same storage and the same stall condition.
module onchip_ram_dp_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  // Reject illegal builds at elaboration.
  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("onchip_ram_dp_pipe: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_width
      $error("onchip_ram_dp_pipe: DATA_WIDTH must be a multiple of 8 in 8..128");
    end
  endgenerate

  logic stall;
  logic s1_wr_acc, s2_wr_acc;
  logic s1_rd_acc, s2_rd_acc;

  // Nothing is accepted while clock-enable is low or a reset is pending.
  assign stall          = ~clken | reset_req;
  assign s1_waitrequest = stall;
  assign s2_waitrequest = stall;

  // read+write together is a write only, so a port can never read its own write.
  assign s1_wr_acc = s1_chipselect & s1_write & ~stall;
  assign s2_wr_acc = s2_chipselect & s2_write & ~stall;
  assign s1_rd_acc = s1_chipselect & s1_read & ~s1_write & ~stall;
  assign s2_rd_acc = s2_chipselect & s2_read & ~s2_write & ~stall;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-lane writes from both ports; s2 is applied first so s1 wins any
  // lane both ports enable on the same address.
  // NOTE: the storage array has no reset so it maps onto block RAM; contents
  // survive reset_n by design.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (s2_wr_acc && s2_byteenable[b]) mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      if (s1_wr_acc && s1_byteenable[b]) mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
    end
  end

  logic [DATA_WIDTH-1:0] s1_st1_data, s2_st1_data;
  logic                  s1_st1_valid, s2_st1_valid;

  // First read stage: registered array read; holds while stalled.
  // NOTE: non-blocking assignments here mean a same-edge write from the other
  // port is not yet visible, so a colliding read returns the old contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_st1_data  <= '0;
      s1_st1_valid <= 1'b0;
      s2_st1_data  <= '0;
      s2_st1_valid <= 1'b0;
    end else if (!stall) begin
      s1_st1_valid <= s1_rd_acc;
      s2_st1_valid <= s2_rd_acc;
      if (s1_rd_acc) s1_st1_data <= mem[s1_address];
      if (s2_rd_acc) s2_st1_data <= mem[s2_address];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s1_st2_data, s2_st2_data;
      logic                  s1_st2_valid, s2_st2_valid;

      // Extra output stage; data only loads on a valid beat so it holds otherwise.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_st2_data  <= '0;
          s1_st2_valid <= 1'b0;
          s2_st2_data  <= '0;
          s2_st2_valid <= 1'b0;
        end else if (!stall) begin
          s1_st2_valid <= s1_st1_valid;
          s2_st2_valid <= s2_st1_valid;
          if (s1_st1_valid) s1_st2_data <= s1_st1_data;
          if (s2_st1_valid) s2_st2_data <= s2_st1_data;
        end
      end

      assign s1_readdata      = s1_st2_data;
      assign s1_readdatavalid = s1_st2_valid;
      assign s2_readdata      = s2_st2_data;
      assign s2_readdatavalid = s2_st2_valid;
    end else begin : g_lat1
      assign s1_readdata      = s1_st1_data;
      assign s1_readdatavalid = s1_st1_valid;
      assign s2_readdata      = s2_st1_data;
      assign s2_readdatavalid = s2_st1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_onchip_ram_dp_pipe.sv
// Directed bench: one latency-1 and one latency-2 instance share all inputs,
// so every scenario is checked against both read pipelines.
module tb_onchip_ram_dp_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clken;
  logic        reset_req;
  logic [10:0] addr [2];
  logic        cs   [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [3:0]  be   [2];
  logic [31:0] wd   [2];

  logic [31:0] rdata1 [2];
  logic [31:0] rdata2 [2];
  logic        valid1 [2];
  logic        valid2 [2];
  logic        wait1  [2];
  logic        wait2  [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  onchip_ram_dp_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .READ_LATENCY(1)) u_dut_lat1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdata1[0]),
    .s1_readdatavalid(valid1[0]), .s1_waitrequest(wait1[0]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdata1[1]),
    .s2_readdatavalid(valid1[1]), .s2_waitrequest(wait1[1])
  );

  onchip_ram_dp_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .READ_LATENCY(2)) u_dut_lat2 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdata2[0]),
    .s1_readdatavalid(valid2[0]), .s1_waitrequest(wait2[0]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdata2[1]),
    .s2_readdatavalid(valid2[1]), .s2_waitrequest(wait2[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0; be[p] = 4'h0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic [10:0] a, input logic [31:0] d, input logic [3:0] b);
    addr[p] = a; cs[p] = 1'b1; wr[p] = 1'b1; rd[p] = 1'b0; be[p] = b; wd[p] = d;
  endtask

  task automatic set_rd(input int p, input logic [10:0] a);
    addr[p] = a; cs[p] = 1'b1; rd[p] = 1'b1; wr[p] = 1'b0;
  endtask

  task automatic do_wr(input int p, input logic [10:0] a, input logic [31:0] d, input logic [3:0] b);
    set_wr(p, a, d, b);
    step();
    idle();
  endtask

  // Single read: latency-1 valid one cycle after accept, latency-2 two cycles.
  task automatic do_rd(input int p, input logic [10:0] a, input logic [31:0] exp, input string tag);
    set_rd(p, a);
    step();
    idle();
    check({tag, " lat1 valid"}, {31'd0, valid1[p]}, 32'd1);
    check({tag, " lat1 data"}, rdata1[p], exp);
    check({tag, " lat2 early valid"}, {31'd0, valid2[p]}, 32'd0);
    step();
    check({tag, " lat1 single pulse"}, {31'd0, valid1[p]}, 32'd0);
    check({tag, " lat1 data hold"}, rdata1[p], exp);
    check({tag, " lat2 valid"}, {31'd0, valid2[p]}, 32'd1);
    check({tag, " lat2 data"}, rdata2[p], exp);
    step();
    check({tag, " lat2 single pulse"}, {31'd0, valid2[p]}, 32'd0);
  endtask

  // Back-to-back stall stimulus: clken and read address per cycle.
  logic        st_clken [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  logic        st_rd    [12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  logic [10:0] st_addr  [12] = '{0, 1, 2, 2, 2, 2, 3, 0, 0, 0, 0, 0};

  initial begin
    int n1, n2;
    logic [31:0] seen1 [4];
    logic [31:0] seen2 [4];

    reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
    for (int p = 0; p < 2; p++) begin addr[p] = '0; wd[p] = '0; end
    idle();
    step(); step();
    for (int p = 0; p < 2; p++) begin
      check("reset lat1 data", rdata1[p], 32'd0);
      check("reset lat1 valid", {31'd0, valid1[p]}, 32'd0);
      check("reset lat2 data", rdata2[p], 32'd0);
      check("reset lat2 valid", {31'd0, valid2[p]}, 32'd0);
      check("idle waitrequest", {31'd0, wait1[p]}, 32'd0);
    end
    reset_n = 1'b1;
    step();

    // 1: full write, read back on both ports
    do_wr(0, 11'h005, 32'hDEADBEEF, 4'hF);
    do_rd(0, 11'h005, 32'hDEADBEEF, "t1 s1");
    do_rd(1, 11'h005, 32'hDEADBEEF, "t1 s2");

    // 2: partial byte enables, then an all-zero byteenable no-op
    do_wr(0, 11'h010, 32'h11223344, 4'hF);
    do_wr(0, 11'h010, 32'hAABBCCDD, 4'b0101);
    do_rd(0, 11'h010, 32'h11BB33DD, "t2 partial");
    do_wr(1, 11'h010, 32'hFFFFFFFF, 4'h0);
    do_rd(1, 11'h010, 32'h11BB33DD, "t2 be0 noop");

    // read+write together counts as a write and produces no valid
    set_wr(0, 11'h011, 32'h12345678, 4'hF);
    rd[0] = 1'b1;
    step();
    idle();
    check("rw lat1 no valid", {31'd0, valid1[0]}, 32'd0);
    step();
    check("rw lat2 no valid", {31'd0, valid2[0]}, 32'd0);
    do_rd(0, 11'h011, 32'h12345678, "rw as write");

    // 3: same-address write collision, s1 wins shared lanes
    do_wr(0, 11'h020, 32'h00000000, 4'hF);
    set_wr(0, 11'h020, 32'hAAAAAAAA, 4'b0011);
    set_wr(1, 11'h020, 32'h55555555, 4'b0110);
    step();
    idle();
    do_rd(1, 11'h020, 32'h0055AAAA, "t3 collision");

    // 4: mixed-port read during write returns old data
    do_wr(0, 11'h030, 32'h1, 4'hF);
    set_wr(0, 11'h030, 32'h2, 4'hF);
    set_rd(1, 11'h030);
    step();
    idle();
    check("t4 lat1 valid", {31'd0, valid1[1]}, 32'd1);
    check("t4 lat1 old data", rdata1[1], 32'h1);
    check("t4 s1 no valid", {31'd0, valid1[0]}, 32'd0);
    step();
    check("t4 lat2 valid", {31'd0, valid2[1]}, 32'd1);
    check("t4 lat2 old data", rdata2[1], 32'h1);
    step();
    do_rd(1, 11'h030, 32'h2, "t4 new data");

    // 5: back-to-back reads with clken dropped for 3 cycles after 2nd accept.
    // A valid only counts in a cycle where waitrequest is low.
    for (int i = 0; i < 4; i++) do_wr(0, 11'(i), 32'hA0 + 32'(i), 4'hF);
    step();
    n1 = 0; n2 = 0;
    for (int k = 0; k < 12; k++) begin
      clken = st_clken[k];
      if (st_rd[k]) set_rd(0, st_addr[k]); else idle();
      #1;
      check("t5 waitrequest lat1", {31'd0, wait1[0]}, {31'd0, ~st_clken[k]});
      check("t5 waitrequest lat2", {31'd0, wait2[0]}, {31'd0, ~st_clken[k]});
      if (!wait1[0] && valid1[0]) begin
        if (n1 < 4) seen1[n1] = rdata1[0];
        n1++;
      end
      if (!wait2[0] && valid2[0]) begin
        if (n2 < 4) seen2[n2] = rdata2[0];
        n2++;
      end
      @(posedge clk);
      #1;
    end
    idle();
    clken = 1'b1;
    check("t5 lat1 pulse count", 32'(n1), 32'd4);
    check("t5 lat2 pulse count", 32'(n2), 32'd4);
    for (int i = 0; i < 4 && i < n1; i++) check("t5 lat1 order", seen1[i], 32'hA0 + 32'(i));
    for (int i = 0; i < 4 && i < n2; i++) check("t5 lat2 order", seen2[i], 32'hA0 + 32'(i));

    // reset_req stalls and blocks writes
    do_wr(0, 11'h040, 32'h0, 4'hF);
    reset_req = 1'b1;
    set_wr(0, 11'h040, 32'hFFFFFFFF, 4'hF);
    #1;
    check("reset_req wait s1", {31'd0, wait1[0]}, 32'd1);
    check("reset_req wait s2", {31'd0, wait2[1]}, 32'd1);
    step();
    idle();
    reset_req = 1'b0;
    do_rd(0, 11'h040, 32'h0, "reset_req no write");

    // 6: reset drops an in-flight read but keeps memory
    set_rd(1, 11'h005);
    step();
    idle();
    reset_n = 1'b0;
    #1;
    check("t6 lat1 valid cleared", {31'd0, valid1[1]}, 32'd0);
    check("t6 lat1 data cleared", rdata1[1], 32'd0);
    check("t6 lat2 data cleared", rdata2[1], 32'd0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t6 lat2 no valid", {31'd0, valid2[1]}, 32'd0);
      check("t6 lat1 no valid", {31'd0, valid1[1]}, 32'd0);
      step();
    end
    do_rd(1, 11'h005, 32'hDEADBEEF, "t6 mem kept");
    do_rd(0, 11'h020, 32'h0055AAAA, "t6 mem kept 2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
